// File: rtl/mm_dma.sv
// mm_dma: host-side initiator for the 4x4 matrix-multiply accelerator.
// Kicks the accelerator over AXI-Lite, streams 32 operand words out of SRAM,
// captures 16 result words back into SRAM, then polls ap_done.
module mm_dma #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pMEM_AW     = 10,
  parameter int unsigned pIN_LEN     = 32,
  parameter int unsigned pOUT_LEN    = 16
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   start,
  input  logic [pMEM_AW-1:0]     src_base,
  input  logic [pMEM_AW-1:0]     dst_base,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_ren,
  output logic [pMEM_AW-1:0]     mem_raddr,
  input  logic [pDATA_WIDTH-1:0] mem_rdata,
  output logic                   mem_wen,
  output logic [pMEM_AW-1:0]     mem_waddr,
  output logic [pDATA_WIDTH-1:0] mem_wdata,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wready,
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arready,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rready,
  output logic                   ss_tvalid,
  output logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tlast,
  input  logic                   ss_tready,
  input  logic                   sm_tvalid,
  input  logic [pDATA_WIDTH-1:0] sm_tdata,
  input  logic                   sm_tlast,
  output logic                   sm_tready
);

  localparam int unsigned idx_w = $clog2(pIN_LEN + 1);
  localparam int unsigned out_w = $clog2(pOUT_LEN + 1);
  localparam logic [idx_w-1:0] in_len  = idx_w'(pIN_LEN);
  localparam logic [idx_w-1:0] in_last = idx_w'(pIN_LEN - 1);
  localparam logic [out_w-1:0] out_len = out_w'(pOUT_LEN);
  // ap_ctrl register lives at offset 0; bit 0 is ap_start, bit 1 is ap_done
  localparam logic [pADDR_WIDTH-1:0] ap_ctrl_addr = '0;

  typedef enum logic [2:0] {StIdle, StCfg, StStream, StPollAr, StPollR, StDone} state_t;

  state_t state_q, state_d;

  logic [pMEM_AW-1:0]     src_q, dst_q;
  logic [idx_w-1:0]       rd_idx_q, send_idx_q;
  logic [out_w-1:0]       out_idx_q;
  logic                   aw_done_q, w_done_q;
  logic                   inflight_q;
  logic [pDATA_WIDTH-1:0] fifo_q [2];
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             count_q;
  logic                   mem_wen_q;
  logic [pMEM_AW-1:0]     mem_waddr_q;
  logic [pDATA_WIDTH-1:0] mem_wdata_q;

  logic       aw_hs, w_hs, ss_pop, sm_fire;
  logic [2:0] credit_used;

  // sm_tlast is not needed: the result count alone ends the job
  logic unused_ok;
  assign unused_ok = ^{sm_tlast, rdata[pDATA_WIDTH-1:2], rdata[0]};

  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign ss_pop  = ss_tvalid & ss_tready;
  assign sm_fire = sm_tvalid & sm_tready;

  assign ss_tvalid = (count_q != 2'd0);
  assign ss_tdata  = ss_tvalid ? fifo_q[rd_ptr_q] : '0;
  assign ss_tlast  = ss_tvalid && (send_idx_q == in_last);

  // Occupancy is counted net of a same-cycle pop so a steady stream issues one read per cycle
  assign credit_used = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, ss_pop};

  assign mem_wen   = mem_wen_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;

  // State register
  always_ff @(posedge axis_clk) begin
    if (axis_rst) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StCfg;
      StCfg:    if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = StStream;
      StStream: if ((send_idx_q == in_len) && (out_idx_q == out_len)) state_d = StPollAr;
      StPollAr: if (arready) state_d = StPollR;
      StPollR:  if (rvalid) state_d = rdata[1] ? StDone : StPollAr;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Control outputs decoded from the current state
  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    awvalid   = (state_q == StCfg) && !aw_done_q;
    wvalid    = (state_q == StCfg) && !w_done_q;
    awaddr    = ap_ctrl_addr;
    wdata     = pDATA_WIDTH'(wvalid);
    arvalid   = (state_q == StPollAr);
    araddr    = ap_ctrl_addr;
    rready    = (state_q == StPollR);
    sm_tready = (state_q == StStream) && (out_idx_q < out_len);
    mem_ren   = (state_q == StStream) && (rd_idx_q < in_len) && (credit_used < 3'd2);
    mem_raddr = mem_ren ? (src_q + pMEM_AW'(rd_idx_q)) : '0;
  end

  // Job context, handshake flags, read pipeline, skid FIFO and result counters
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      src_q      <= '0;
      dst_q      <= '0;
      rd_idx_q   <= '0;
      send_idx_q <= '0;
      out_idx_q  <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
    end else if ((state_q == StIdle) && start) begin
      src_q      <= src_base;
      dst_q      <= dst_base;
      rd_idx_q   <= '0;
      send_idx_q <= '0;
      out_idx_q  <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if (mem_ren) rd_idx_q <= rd_idx_q + idx_w'(1);
      inflight_q <= mem_ren;
      // SRAM data is valid the cycle after the read was issued
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= mem_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (ss_pop) begin
        rd_ptr_q   <= ~rd_ptr_q;
        send_idx_q <= send_idx_q + idx_w'(1);
      end
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, ss_pop};
      if (sm_fire) out_idx_q <= out_idx_q + out_w'(1);
    end
  end

  // Registered SRAM write of each accepted result word
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      mem_wen_q   <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_wen_q   <= sm_fire;
      mem_waddr_q <= sm_fire ? (dst_q + pMEM_AW'(out_idx_q)) : '0;
      mem_wdata_q <= sm_fire ? sm_tdata : '0;
    end
  end

endmodule

// File: tb/tb_mm_dma.sv
// tb_mm_dma: directed bench for mm_dma with an SRAM model and a behavioural
// 4x4 matrix-multiply accelerator (AXI-Lite control, AXI-Stream data).
module tb_mm_dma;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned MAW = 10;

  logic           axis_clk = 1'b0;
  logic           axis_rst = 1'b1;
  logic           start    = 1'b0;
  logic [MAW-1:0] src_base = '0;
  logic [MAW-1:0] dst_base = '0;
  logic           busy, done, mem_ren, mem_wen;
  logic [MAW-1:0] mem_raddr, mem_waddr;
  logic [DW-1:0]  mem_rdata, mem_wdata;
  logic           awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [AW-1:0]  awaddr, araddr;
  logic [DW-1:0]  wdata, rdata;
  logic           ss_tvalid, ss_tlast, ss_tready, sm_tvalid, sm_tlast, sm_tready;
  logic [DW-1:0]  ss_tdata, sm_tdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Bench knobs (written only by the stimulus block)
  int aw_dly     = 0;
  int idle_polls = 0;
  bit ready_mode = 1'b0;
  bit mon_clr    = 1'b0;

  always #5 axis_clk = ~axis_clk;

  mm_dma dut (
    .axis_clk (axis_clk),  .axis_rst (axis_rst),  .start    (start),
    .src_base (src_base),  .dst_base (dst_base),  .busy     (busy),
    .done     (done),      .mem_ren  (mem_ren),   .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .mem_wen  (mem_wen),   .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .awvalid  (awvalid),   .awaddr   (awaddr),
    .awready  (awready),   .wvalid   (wvalid),    .wdata    (wdata),
    .wready   (wready),    .arvalid  (arvalid),   .araddr   (araddr),
    .arready  (arready),   .rvalid   (rvalid),    .rdata    (rdata),
    .rready   (rready),    .ss_tvalid(ss_tvalid), .ss_tdata (ss_tdata),
    .ss_tlast (ss_tlast),  .ss_tready(ss_tready), .sm_tvalid(sm_tvalid),
    .sm_tdata (sm_tdata),  .sm_tlast (sm_tlast),  .sm_tready(sm_tready)
  );

  // Source image: word i of a job is B = identity for i<16, A = 1..16 for 16<=i<32
  function automatic logic [31:0] src_word(input int i);
    if (i < 16) return ((i % 5) == 0) ? 32'd1 : 32'd0;
    else if (i < 32) return 32'(i - 15);
    else return 32'hDEAD_BEEF;
  endfunction

  // SRAM model: reads decode the offset from src_base, writes land in wmem
  logic [31:0]    wmem [1024];
  logic [MAW-1:0] rd_off;
  assign rd_off = mem_raddr - src_base;
  always @(posedge axis_clk) begin
    if (mem_ren) mem_rdata <= src_word(int'(rd_off));
    if (mem_wen) wmem[mem_waddr] <= mem_wdata;
  end

  // AXI-Lite slave: awready may lag awvalid by aw_dly cycles
  int aw_wait = 0;
  always @(posedge axis_clk) begin
    if (!awvalid || awready) aw_wait <= 0;
    else aw_wait <= aw_wait + 1;
  end
  assign awready = awvalid && (aw_wait >= aw_dly);
  assign wready  = wvalid;
  assign arready = arvalid;

  // Accelerator model
  logic [31:0] bmat [16];
  logic [31:0] amat [16];
  int          in_cnt, out_cnt, polls_left;
  bit          ap_done, rpend;
  logic [31:0] rdata_q;
  always @(posedge axis_clk) begin
    if (axis_rst) begin
      in_cnt <= 0; out_cnt <= 0; ap_done <= 1'b0; rpend <= 1'b0;
      rdata_q <= 32'd0; polls_left <= idle_polls;
    end else begin
      if (ss_tvalid && ss_tready) begin
        if (in_cnt < 16) bmat[in_cnt[3:0]] <= ss_tdata;
        else if (in_cnt < 32) amat[4'(in_cnt - 16)] <= ss_tdata;
        in_cnt <= in_cnt + 1;
      end
      if (sm_tvalid && sm_tready) begin
        out_cnt <= out_cnt + 1;
        if (out_cnt == 15) ap_done <= 1'b1;
      end
      if (arvalid && arready) begin
        rpend <= 1'b1;
        if (polls_left > 0) begin
          rdata_q    <= 32'd4;
          polls_left <= polls_left - 1;
        end else begin
          rdata_q <= ap_done ? 32'd2 : 32'd4;
        end
      end else if (rvalid && rready) begin
        rpend <= 1'b0;
      end
    end
  end
  assign rvalid    = rpend;
  assign rdata     = rdata_q;
  assign sm_tvalid = (in_cnt == 32) && (out_cnt < 16);
  assign sm_tlast  = sm_tvalid && (out_cnt == 15);
  always_comb begin
    sm_tdata = '0;
    for (int k = 0; k < 4; k++)
      sm_tdata += amat[4'(((out_cnt / 4) % 4) * 4 + k)] * bmat[4'(k * 4 + (out_cnt % 4))];
  end

  // Input-stream ready pattern 1,0,0,1 when ready_mode is set
  int tcnt = 0;
  always @(posedge axis_clk) tcnt <= tcnt + 1;
  assign ss_tready = !ready_mode || ((tcnt % 4) == 0) || ((tcnt % 4) == 3);

  // Monitor, sampled mid-cycle
  int          ncyc = 0;
  int          aw_n, w_n, ar_n, r_n, done_n, ren_n, ss_n, wr_n, tlast_n, tlast_idx;
  int          stall_n, unstable_n, aw_cyc, w_cyc, r_cyc, done_cyc, first_ren_cyc;
  logic [31:0] last_awaddr, last_wdata, last_araddr, prev_data;
  bit          prev_stall;
  logic [31:0] ss_log [64];
  logic [9:0]  ren_log [64];
  always @(negedge axis_clk) begin
    ncyc <= ncyc + 1;
    if (mon_clr) begin
      aw_n <= 0; w_n <= 0; ar_n <= 0; r_n <= 0; done_n <= 0; ren_n <= 0; ss_n <= 0;
      wr_n <= 0; tlast_n <= 0; tlast_idx <= -1; stall_n <= 0; unstable_n <= 0;
      aw_cyc <= 0; w_cyc <= 0; r_cyc <= 0; done_cyc <= 0; first_ren_cyc <= 0;
      last_awaddr <= 32'hFFFF_FFFF; last_wdata <= 32'hFFFF_FFFF;
      last_araddr <= 32'hFFFF_FFFF; prev_stall <= 1'b0; prev_data <= 32'd0;
    end else begin
      if (awvalid && awready) begin
        aw_n <= aw_n + 1; aw_cyc <= ncyc; last_awaddr <= 32'(awaddr);
      end
      if (wvalid && wready) begin
        w_n <= w_n + 1; w_cyc <= ncyc; last_wdata <= wdata;
      end
      if (arvalid && arready) begin
        ar_n <= ar_n + 1; last_araddr <= 32'(araddr);
      end
      if (rvalid && rready) begin
        r_n <= r_n + 1; r_cyc <= ncyc;
      end
      if (done) begin
        done_n <= done_n + 1; done_cyc <= ncyc;
      end
      if (mem_ren) begin
        if (ren_n < 64) ren_log[6'(ren_n)] <= mem_raddr;
        if (ren_n == 0) first_ren_cyc <= ncyc;
        ren_n <= ren_n + 1;
      end
      if (ss_tvalid && ss_tready) begin
        if (ss_n < 64) ss_log[6'(ss_n)] <= ss_tdata;
        if (ss_tlast) begin
          tlast_n <= tlast_n + 1; tlast_idx <= ss_n;
        end
        ss_n <= ss_n + 1;
      end
      if (ss_tvalid && !ss_tready) stall_n <= stall_n + 1;
      if (prev_stall && (!ss_tvalid || (ss_tdata !== prev_data))) unstable_n <= unstable_n + 1;
      prev_stall <= ss_tvalid && !ss_tready;
      prev_data  <= ss_tdata;
      if (mem_wen) wr_n <= wr_n + 1;
    end
  end

  logic outs_nz;
  assign outs_nz = |{busy, done, mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, awvalid,
                     awaddr, wvalid, wdata, arvalid, araddr, rready, ss_tvalid, ss_tdata,
                     ss_tlast, sm_tready};

  function automatic int ss_bad();
    int b = 0;
    for (int i = 0; i < 32; i++) if (ss_log[i] !== src_word(i)) b++;
    return b;
  endfunction

  // With B = identity the product equals A, i.e. 1..16
  function automatic int res_bad(input logic [9:0] d);
    int b = 0;
    logic [9:0] a;
    for (int k = 0; k < 16; k++) begin
      a = d + 10'(k);
      if (wmem[a] !== 32'(k + 1)) b++;
    end
    return b;
  endfunction

  function automatic int ren_bad(input logic [9:0] s);
    int b = 0;
    logic [9:0] e;
    for (int i = 0; i < 32; i++) begin
      e = s + 10'(i);
      if (ren_log[i] !== e) b++;
    end
    return b;
  endfunction

  task automatic step;
    @(posedge axis_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    axis_rst = 1'b1;
    start    = 1'b0;
    mon_clr  = 1'b1;
    repeat (2) step;
    axis_rst = 1'b0;
    mon_clr  = 1'b0;
    step;
  endtask

  // Runs one job; poke >= 0 pulses start again once that many words have streamed
  task automatic run_job(input logic [9:0] s, input logic [9:0] d, input int poke);
    int k;
    bit poked;
    src_base = s;
    dst_base = d;
    start    = 1'b1;
    step;
    start = 1'b0;
    k     = 0;
    poked = 1'b0;
    while (done_n == 0 && k < 3000) begin
      if (poke >= 0 && !poked && ss_n >= poke) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      step;
      k++;
    end
    start = 1'b0;
    check("job_finished_in_time", 32'(k < 3000), 32'd1);
    repeat (5) step;
  endtask

  initial begin
    int k;

    do_reset;
    check("rst_outputs_zero", 32'(outs_nz), 32'd0);

    // Basic job
    run_job(10'd0, 10'd64, -1);
    check("basic_aw_n", aw_n, 1);
    check("basic_w_n", w_n, 1);
    check("basic_awaddr", last_awaddr, 32'h0);
    check("basic_wdata", last_wdata, 32'h1);
    check("basic_ss_n", ss_n, 32);
    check("basic_ss_order", ss_bad(), 0);
    check("basic_tlast_n", tlast_n, 1);
    check("basic_tlast_idx", tlast_idx, 31);
    check("basic_result", res_bad(10'd64), 0);
    check("basic_wr_n", wr_n, 16);
    check("basic_ar_n", ar_n, 1);
    check("basic_araddr", last_araddr, 32'h0);
    check("basic_done_n", done_n, 1);
    check("basic_idle_after", 32'(outs_nz), 32'd0);

    // Input backpressure
    ready_mode = 1'b1;
    do_reset;
    run_job(10'd0, 10'd200, -1);
    ready_mode = 1'b0;
    check("bp_stalls_seen", 32'(stall_n > 0), 32'd1);
    check("bp_stable", unstable_n, 0);
    check("bp_ss_n", ss_n, 32);
    check("bp_ss_order", ss_bad(), 0);
    check("bp_result", res_bad(10'd200), 0);

    // Delayed AW handshake
    aw_dly = 3;
    do_reset;
    run_job(10'd0, 10'd300, -1);
    aw_dly = 0;
    check("dly_aw_n", aw_n, 1);
    check("dly_w_n", w_n, 1);
    check("dly_aw_after_w", aw_cyc - w_cyc, 3);
    check("dly_stream_after_cfg", 32'(first_ren_cyc > aw_cyc), 32'd1);
    check("dly_result", res_bad(10'd300), 0);

    // Polling: two idle reads then done
    idle_polls = 2;
    do_reset;
    idle_polls = 0;
    run_job(10'd0, 10'd400, -1);
    check("poll_ar_n", ar_n, 3);
    check("poll_r_n", r_n, 3);
    check("poll_done_latency", done_cyc - r_cyc, 1);
    check("poll_done_n", done_n, 1);

    // start while busy is ignored
    do_reset;
    run_job(10'd0, 10'd600, 5);
    repeat (10) step;
    check("busy_start_done_n", done_n, 1);
    check("busy_start_aw_n", aw_n, 1);
    check("busy_start_ss_n", ss_n, 32);
    check("busy_start_result", res_bad(10'd600), 0);
    check("busy_start_idle", 32'(busy), 32'd0);

    // Reset in the middle of streaming
    do_reset;
    src_base = 10'd0;
    dst_base = 10'd700;
    start    = 1'b1;
    step;
    start = 1'b0;
    k     = 0;
    while (ss_n < 10 && k < 500) begin
      step;
      k++;
    end
    check("mid_reached_word10", 32'(ss_n >= 10), 32'd1);
    axis_rst = 1'b1;
    step;
    check("mid_rst_outputs_zero", 32'(outs_nz), 32'd0);
    axis_rst = 1'b0;
    mon_clr  = 1'b1;
    step;
    mon_clr = 1'b0;
    repeat (5) step;
    check("mid_quiet", aw_n + w_n + ren_n + ss_n + wr_n + ar_n + done_n, 0);
    check("mid_outputs_still_zero", 32'(outs_nz), 32'd0);
    run_job(10'd0, 10'd800, -1);
    check("mid_rerun_done_n", done_n, 1);
    check("mid_rerun_ss_order", ss_bad(), 0);
    check("mid_rerun_result", res_bad(10'd800), 0);

    // Source address wrap
    do_reset;
    run_job(10'd1020, 10'd500, -1);
    check("wrap_ren_n", ren_n, 32);
    check("wrap_raddr", ren_bad(10'd1020), 0);
    check("wrap_ss_order", ss_bad(), 0);
    check("wrap_result", res_bad(10'd500), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_dma.md
Name: mm_dma

Overview:
- Host-side initiator for the 4x4 matrix-multiply accelerator.
- Starts the accelerator with an AXI-Lite write of ap_start, then streams the input operands from a local SRAM. The operands are 16 words of B followed by 16 words of A, sent on the accelerator's ss_* AXI-Stream slave.
- While streaming, it collects the 16 result words from the accelerator's sm_* AXI-Stream master into SRAM.
- Afterwards it polls the accelerator's ap_done over AXI-Lite read and pulses done.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite address width.
- pDATA_WIDTH, 32, data width for AXI-Lite, AXI-Stream and SRAM.
- pMEM_AW, 10, SRAM word-address width.
- pIN_LEN, 32, words sent per job.
- pOUT_LEN, 16, words received per job.

Ports:
- axis_clk  in  1  clock
- axis_rst  in  1  reset; synchronous, active-high
- start  in  1  job request pulse
- src_base  in  pMEM_AW  SRAM word address of the first input word
- dst_base  in  pMEM_AW  SRAM word address for the first result
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- mem_ren  out  1  SRAM read enable
- mem_raddr  out  pMEM_AW  SRAM read address
- mem_rdata  in  pDATA_WIDTH  SRAM read data, valid 1 cycle after mem_ren
- mem_wen  out  1  SRAM write enable
- mem_waddr  out  pMEM_AW  SRAM write address
- mem_wdata  out  pDATA_WIDTH  SRAM write data
- awvalid  out  1  AXI-Lite write address valid
- awaddr  out  pADDR_WIDTH  AXI-Lite write address
- awready  in  1  AXI-Lite write address ready
- wvalid  out  1  AXI-Lite write data valid
- wdata  out  pDATA_WIDTH  AXI-Lite write data
- wready  in  1  AXI-Lite write data ready
- arvalid  out  1  AXI-Lite read address valid
- araddr  out  pADDR_WIDTH  AXI-Lite read address
- arready  in  1  AXI-Lite read address ready
- rvalid  in  1  AXI-Lite read data valid
- rdata  in  pDATA_WIDTH  AXI-Lite read data
- rready  out  1  AXI-Lite read data ready
- ss_tvalid  out  1  input stream valid
- ss_tdata  out  pDATA_WIDTH  input stream data
- ss_tlast  out  1  last input word
- ss_tready  in  1  accelerator ready for input
- sm_tvalid  in  1  result stream valid
- sm_tdata  in  pDATA_WIDTH  result stream data
- sm_tlast  in  1  last result word (ignored)
- sm_tready  out  1  ready to accept a result

Behaviour:
- Reset (axis_rst=1 at a clock edge): state IDLE; all counters 0; skid buffer empty; every output 0.
- Reset mid-job aborts immediately. No further AXI or SRAM activity until the next start.
- States: IDLE, CFG, STREAM, POLL_AR, POLL_R, DONE.
- IDLE:
  - On start=1: latch src_base and dst_base, clear counters, go to CFG.
  - busy=1 in every state except IDLE.
  - start is ignored while busy.
- CFG:
  - Drive awaddr=0x00, wdata=0x1 (ap_start).
  - awvalid and wvalid rise together. Each drops independently on its own handshake.
  - Go to STREAM when both handshakes are done; order and same-cycle completion are both legal.
- STREAM, input side:
  - Issue read rd_idx at mem_raddr = src_base + rd_idx, modulo 2^pMEM_AW.
  - Read data lands in a 2-entry skid FIFO that feeds ss_tdata.
  - mem_ren=1 only when rd_idx < pIN_LEN and (FIFO occupancy + in-flight reads) < 2.
  - ss_tvalid = FIFO non-empty.
  - ss_tdata and ss_tvalid stay stable until ss_tready=1. A word transfers on ss_tvalid & ss_tready.
  - ss_tlast=1 exactly on word index pIN_LEN-1.
  - With ss_tready held high and no stalls, throughput is 1 word/cycle after 2 cycles of fill.
- STREAM, output side:
  - sm_tready=1 while out_idx < pOUT_LEN.
  - Each sm_tvalid & sm_tready produces a registered write on the next cycle: mem_wen=1, mem_waddr = dst_base + out_idx (mod 2^pMEM_AW), mem_wdata = sm_tdata. out_idx then increments.
  - The input and output sides run concurrently.
  - Go to POLL_AR when all pIN_LEN words are sent and all pOUT_LEN words are received.
- POLL_AR: arvalid=1, araddr=0x00; on arready go to POLL_R.
- POLL_R:
  - rready=1.
  - On rvalid: if rdata[1]=1 (ap_done) go to DONE, else go to POLL_AR.
  - No timeout.
- DONE: done=1 for one cycle, then IDLE with busy=0.
- awaddr, araddr and wdata are 0 whenever their valid signal is low.

Test Plan:
- Basic job: B = I (identity) at SRAM 0..15, A = 1..16 at 16..31, src=0, dst=64. The model accelerator always ready and done after the last result → one AW/W to 0x00 with wdata=1; 32 ss words in order with ss_tlast on the 32nd; SRAM 64..79 equals A unchanged; one done pulse.
- Input backpressure: ss_tready toggles 1,0,0,1 repeatedly → ss_tdata is held stable during every stall; no word is lost or duplicated; sequence is still 0..31 in order.
- Delayed handshakes: awready arrives 3 cycles after wready → CFG exits only after both; exactly one write handshake of each kind.
- Polling: the model returns rdata=0x4 (idle) twice, then 0x2 (done) → exactly 3 AR handshakes, done one cycle after the third R.
- start while busy: start pulse during STREAM → ignored; exactly one done pulse.
- Reset mid-STREAM: axis_rst after word 10 → all outputs 0 next cycle; a new start then runs a full job correctly.
- Address wrap: src_base=1020 → reads go to 1020..1023, then 0..27.
